// File: rtl/lsu_mem_responder.sv
// Word-organised data memory answering one LSU load/store at a time; response LATENCY cycles after accept.
// Backpressure: response is held until rsp_ready; no new request is taken until the cycle after it drains.
module lsu_mem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH/8-1:0]   req_wmask,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF   = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int CW    = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   offset, word_off;
    logic [DEPTH_LOG2-1:0]   cur_idx, idx_q, sel_idx;
    logic                    cur_inr, inr_q, sel_inr;
    logic                    cur_wr, wr_q, sel_wr;
    logic                    accept, enter_resp, rsp_done;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   mem [2**DEPTH_LOG2];

    // Unsigned wrap of the subtraction makes below-base addresses land far out of range.
    assign offset   = req_addr - BASE_ADDR;
    assign word_off = offset >> OFF;
    assign cur_idx  = word_off[DEPTH_LOG2-1:0];
    assign cur_inr  = (req_addr >= BASE_ADDR) && ((word_off >> DEPTH_LOG2) == '0);
    assign cur_wr   = |req_wmask;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_done  = rsp_valid && rsp_ready;

    // With LATENCY==1 the response is formed on the accept edge, before the latches are loaded.
    assign sel_idx = (state == IDLE) ? cur_idx : idx_q;
    assign sel_inr = (state == IDLE) ? cur_inr : inr_q;
    assign sel_wr  = (state == IDLE) ? cur_wr  : wr_q;

    always_comb begin
        state_next = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx_q     <= '0;
            inr_q     <= 1'b0;
            wr_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= cur_idx;
                inr_q <= cur_inr;
                wr_q  <= cur_wr;
                cnt   <= CW'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= !sel_inr;
                rsp_rdata <= (!sel_wr && sel_inr) ? mem[sel_idx] : '0;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Writes commit on the accept edge, so a later reset cannot undo them.
    always_ff @(posedge clk) begin
        if (accept && cur_wr && cur_inr) begin
            for (int b = 0; b < LANES; b++) begin
                if (req_wmask[b]) mem[cur_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_responder.sv
module tb_lsu_mem_responder;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr  = '0;
    logic [3:0]  req_wmask = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int passes = 0;

    lsu_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10),
        .BASE_ADDR(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    endtask

    // Reference model: a plain word array plus "one transaction in flight" bookkeeping.
    logic [31:0] mm [1024];
    bit          busy = 0;
    bit          pend = 0;
    int          due  = 0;
    int          cyc  = 0;
    int          idx;
    logic [31:0] e_rd;
    logic        e_err;

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd4096);
    endfunction

    always @(negedge clk) begin
        cyc++;
        chk("req_ready", {31'b0, req_ready}, {31'b0, !rst && !busy});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, pend && cyc >= due});
        if (pend && cyc >= due) begin
            chk("rsp_rdata", rsp_rdata, e_rd);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
        end else begin
            chk("idle_rdata", rsp_rdata, 32'h0);
            chk("idle_err", {31'b0, rsp_err}, 32'h0);
        end
        if (rst) begin
            busy = 0;
            pend = 0;
        end else if (!busy && req_valid) begin
            busy = 1;
            pend = 1;
            due  = cyc + LAT;
            e_rd = 32'h0;
            if (in_rng(req_addr)) begin
                e_err = 1'b0;
                idx   = int'((req_addr - BASE) >> 2);
                if (req_wmask == 4'h0) e_rd = mm[idx];
                else
                    for (int b = 0; b < 4; b++)
                        if (req_wmask[b]) mm[idx][b*8 +: 8] = req_wdata[b*8 +: 8];
            end else begin
                e_err = 1'b1;
            end
        end else if (pend && cyc >= due && rsp_ready) begin
            busy = 0;
            pend = 0;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        int n = 0;
        req_addr = a; req_wmask = m; req_wdata = d; req_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        if (!req_ready) chk("accept_timeout", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_wmask = '0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic e, output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
        if (!rsp_valid) chk("rsp_timeout", {31'b0, rsp_valid}, 32'h1);
        rd = rsp_rdata;
        e  = rsp_err;
    endtask

    task automatic xact(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
        issue(a, m, d);
        wait_rsp(rd, e, lat);
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    bit          seen;

    initial begin
        // T1 reset
        repeat (2) @(negedge clk);
        chk("t1_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("t1_rsp_err",   {31'b0, rsp_err},   32'h0);
        chk("t1_rsp_rdata", rsp_rdata,          32'h0);
        chk("t1_req_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t1_ready_after", {31'b0, req_ready}, 32'h1);

        // T2 write / read
        xact(32'h8000_0010, 4'hF, 32'hDEAD_BEEF, rd, e, lat);
        chk("t2_wr_lat", lat, 32'd2);
        chk("t2_wr_err", {31'b0, e}, 32'h0);
        chk("t2_wr_rdata", rd, 32'h0);
        xact(32'h8000_0010, 4'h0, 32'h0, rd, e, lat);
        chk("t2_rd", rd, 32'hDEAD_BEEF);

        // T3 byte mask
        xact(32'h8000_0010, 4'b0010, 32'h0000_AA00, rd, e, lat);
        xact(32'h8000_0010, 4'h0, 32'h0, rd, e, lat);
        chk("t3_rd", rd, 32'hDEAD_AAEF);

        // T4 backpressure
        rsp_ready = 1'b0;
        issue(32'h8000_0010, 4'h0, 32'h0);
        wait_rsp(rd, e, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'b0, rsp_valid}, 32'h1);
            chk("t4_hold_rdata", rsp_rdata, 32'hDEAD_AAEF);
            chk("t4_hold_ready", {31'b0, req_ready}, 32'h0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_ready_pre", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        chk("t4_ready_post", {31'b0, req_ready}, 32'h1);
        chk("t4_valid_post", {31'b0, rsp_valid}, 32'h0);
        @(posedge clk); #1;

        // T5 range
        xact(32'h8000_0000, 4'hF, 32'hCAFE_F00D, rd, e, lat);
        xact(32'h8000_0FFC, 4'hF, 32'h0BAD_C0DE, rd, e, lat);
        xact(32'h8000_0FFC, 4'h0, 32'h0, rd, e, lat);
        chk("t5_top_rd", rd, 32'h0BAD_C0DE);
        chk("t5_top_err", {31'b0, e}, 32'h0);
        xact(32'h7FFF_FFFC, 4'h0, 32'h0, rd, e, lat);
        chk("t5_low_err", {31'b0, e}, 32'h1);
        chk("t5_low_rd", rd, 32'h0);
        xact(32'h8000_1000, 4'h0, 32'h0, rd, e, lat);
        chk("t5_high_err", {31'b0, e}, 32'h1);
        chk("t5_high_rd", rd, 32'h0);
        xact(32'h8000_1000, 4'hF, 32'h1111_1111, rd, e, lat);
        chk("t5_oor_wr_err", {31'b0, e}, 32'h1);
        xact(32'h8000_0000, 4'h0, 32'h0, rd, e, lat);
        chk("t5_word0", rd, 32'hCAFE_F00D);

        // T6 reset while waiting
        issue(32'h8000_0020, 4'hF, 32'h1234_5678);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (8) begin @(negedge clk); seen |= rsp_valid; end
        chk("t6_no_rsp", {31'b0, seen}, 32'h0);
        xact(32'h8000_0020, 4'h0, 32'h0, rd, e, lat);
        chk("t6_rd", rd, 32'h1234_5678);
        chk("t6_err", {31'b0, e}, 32'h0);
        chk("t6_lat", lat, 32'd2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
